// File: rtl/sparc_exu_aludiv64.sv
// 64-by-32 restoring divider for UDIV/SDIV: one quotient bit per cycle, with
// SPARC-style saturation on overflow and an explicit divide-by-zero flag.
module sparc_exu_aludiv64 (
  input  logic        clk,
  input  logic        arst_l,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [63:0] div_dividend,
  input  logic [31:0] div_divisor,
  input  logic        div_kill,
  input  logic        div_ack,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem,
  output logic        div_ovf,
  output logic        div_zero
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      r_state;
  logic        r_signed;
  logic [63:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_absDivisor;
  logic [31:0] r_prem;
  logic [31:0] r_shift;
  logic [4:0]  r_cnt;
  logic        r_quotNeg;
  logic        r_remNeg;

  logic [63:0] w_absDividend;
  logic [31:0] w_absDivisor;
  logic        w_prepQuotNeg;
  logic [31:0] w_prepSat;
  logic [32:0] w_trial;
  logic        w_noBorrow;
  logic [31:0] w_diff;
  logic        w_fixOvf;
  logic [31:0] w_fixSat;

  assign w_absDividend = (r_signed && r_dividend[63]) ? (~r_dividend + 64'd1) : r_dividend;
  assign w_absDivisor  = (r_signed && r_divisor[31])  ? (~r_divisor + 32'd1)  : r_divisor;
  assign w_prepQuotNeg = r_signed & (r_dividend[63] ^ r_divisor[31]);
  assign w_prepSat     = !r_signed ? 32'hFFFF_FFFF :
                         (w_prepQuotNeg ? 32'h8000_0000 : 32'h7FFF_FFFF);

  // Trial subtract of the divisor from {partial remainder, next dividend bit};
  // the partial remainder stays below the divisor, so the low 32 bits suffice.
  assign w_trial    = {r_prem, r_shift[31]};
  assign w_noBorrow = (w_trial >= {1'b0, r_absDivisor});
  assign w_diff     = w_trial[31:0] - r_absDivisor;

  assign w_fixOvf = r_signed && (r_quotNeg ? (r_shift > 32'h8000_0000)
                                           : (r_shift > 32'h7FFF_FFFF));
  assign w_fixSat = r_quotNeg ? 32'h8000_0000 : 32'h7FFF_FFFF;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      r_state      <= IDLE;
      r_signed     <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_absDivisor <= '0;
      r_prem       <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_quotNeg    <= 1'b0;
      r_remNeg     <= 1'b0;
      div_busy     <= 1'b0;
      div_done     <= 1'b0;
      div_quot     <= '0;
      div_rem      <= '0;
      div_ovf      <= 1'b0;
      div_zero     <= 1'b0;
    end else if (div_kill) begin
      r_state  <= IDLE;
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_ovf  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (div_start) begin
            r_signed   <= div_signed;
            r_dividend <= div_dividend;
            r_divisor  <= div_divisor;
            div_busy   <= 1'b1;
            r_state    <= PREP;
          end
        end
        PREP: begin
          r_absDivisor <= w_absDivisor;
          r_quotNeg    <= w_prepQuotNeg;
          r_remNeg     <= r_signed & r_dividend[63];
          if (r_divisor == 32'd0) begin
            div_zero <= 1'b1;
            div_ovf  <= 1'b0;
            div_quot <= '0;
            div_rem  <= '0;
            div_done <= 1'b1;
            r_state  <= DONE;
          end else if (w_absDividend[63:32] >= w_absDivisor) begin
            // Quotient cannot fit in 32 bits even before sign handling.
            div_zero <= 1'b0;
            div_ovf  <= 1'b1;
            div_quot <= w_prepSat;
            div_rem  <= '0;
            div_done <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_prem  <= w_absDividend[63:32];
            r_shift <= w_absDividend[31:0];
            r_cnt   <= '0;
            r_state <= ITER;
          end
        end
        ITER: begin
          r_prem  <= w_noBorrow ? w_diff : {r_prem[30:0], r_shift[31]};
          r_shift <= {r_shift[30:0], w_noBorrow};
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          div_zero <= 1'b0;
          div_done <= 1'b1;
          r_state  <= DONE;
          if (w_fixOvf) begin
            div_ovf  <= 1'b1;
            div_quot <= w_fixSat;
            div_rem  <= '0;
          end else begin
            div_ovf  <= 1'b0;
            div_quot <= r_quotNeg ? (~r_shift + 32'd1) : r_shift;
            div_rem  <= r_remNeg  ? (~r_prem + 32'd1)  : r_prem;
          end
        end
        DONE: begin
          if (div_ack) begin
            div_done <= 1'b0;
            div_busy <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          div_busy <= 1'b0;
          div_done <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
